sdspi_writer: RTL

//  Sector writer for the SD-SPI controller: streams 512 user bytes into the controller block

---
 rtl/sdspi_writer_pkg.sv | 28 ++
 rtl/sdspi_apb_wr.sv | 54 +++++
 rtl/sdspi_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sdspi_writer_pkg.sv
// Shared constants for the SD-SPI sector writer: controller address map,
// writer state encodings and a helper for the controller-idle test.
package sdspi_writer_pkg;

    localparam logic [15:0] SDSPI_BLOCKADDR = 16'h1000;
    localparam logic [15:0] SDSPI_WRADDR    = 16'h0020;
    localparam int unsigned SDSPI_BLOCKSIZE = 512;

    localparam int unsigned APB_AW = 16;
    localparam int unsigned APB_DW = 32;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_FILL    = 4'd1;
    localparam logic [3:0] ST_BSETUP  = 4'd2;
    localparam logic [3:0] ST_BACCESS = 4'd3;
    localparam logic [3:0] ST_CSETUP  = 4'd4;
    localparam logic [3:0] ST_CACCESS = 4'd5;
    localparam logic [3:0] ST_WBUSY   = 4'd6;
    localparam logic [3:0] ST_WIDLE   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;
    localparam logic [3:0] ST_ERR     = 4'd9;

    // Controller is free when not busy and both its ctrl and sd state machines are home.
    function automatic logic sd_idle(input logic busy, input logic [31:0] status);
        return !busy && (status[15:0] == 16'h0000);
    endfunction

endpackage

// File: rtl/sdspi_apb_wr.sv
// Single APB write transfer: the caller pulses start during the setup cycle and
// holds addr/data stable until done; abort drops an access phase without pready.
module sdspi_apb_wr
    import sdspi_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [APB_AW-1:0] addr,
    input  logic [APB_DW-1:0] data,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [APB_DW-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              done,
    output logic              err
);

    logic access_q;
    logic access_d;

    always_comb begin
        access_d = access_q;
        if (access_q) begin
            if (pready || abort) begin
                access_d = 1'b0;
            end
        end else if (start) begin
            access_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            access_q <= 1'b0;
        end else begin
            access_q <= access_d;
        end
    end

    // Bus outputs are combinational so an async reset drops them at once.
    assign psel    = start || access_q;
    assign penable = access_q;
    assign pwrite  = psel;
    assign paddr   = psel ? addr : '0;
    assign pwdata  = psel ? data : '0;
    assign done    = access_q && pready;
    assign err     = done && pslverr;

endmodule

// File: rtl/sdspi_writer.sv
// Sector writer: pulls BLKSIZE user bytes into the controller block buffer over APB,
// issues the write-sector command and waits for the card to go busy and idle again.
module sdspi_writer
    import sdspi_writer_pkg::*;
#(
    parameter int unsigned BLKSIZE   = SDSPI_BLOCKSIZE,
    parameter logic [15:0] BLK_BASE  = SDSPI_BLOCKADDR,
    parameter logic [15:0] WCMD_ADDR = SDSPI_WRADDR,
    parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        wstart,
    input  logic [31:0] wsector,
    output logic        wbusy,
    output logic        wdone,
    output logic        werr,
    output logic        inready,
    input  logic        invalid,
    output logic [8:0]  inaddr,
    input  logic [7:0]  inbyte,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        sdsbusy,
    input  logic [31:0] sdspi_status,
    output logic [31:0] w_writer_status
);

    localparam logic [9:0] LAST = 10'(BLKSIZE - 1);

    logic [3:0]  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] sector_q, sector_d;
    logic        werr_q, werr_d;
    logic [7:0]  code_q, code_d;
    logic [23:0] tmo_q, tmo_d;

    logic        tmo_hit;
    logic        cmd_phase;
    logic        apb_start, apb_abort, apb_done, apb_err;
    logic [15:0] apb_addr;
    logic [31:0] apb_data;
    logic        unused_status;

    assign unused_status = ^sdspi_status[31:16];
    assign tmo_hit       = (tmo_q == TIMEOUT - 24'd1);
    assign cmd_phase     = (state_q == ST_CSETUP) || (state_q == ST_CACCESS);
    assign apb_addr      = cmd_phase ? WCMD_ADDR : BLK_BASE + {6'h00, cnt_q};
    assign apb_data      = cmd_phase ? sector_q : {24'h000000, byte_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        sector_d  = sector_q;
        werr_d    = werr_q;
        code_d    = code_q;
        apb_start = 1'b0;
        apb_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wstart && sd_idle(sdsbusy, sdspi_status)) begin
                    sector_d = wsector;
                    cnt_d    = '0;
                    werr_d   = 1'b0;
                    code_d   = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (invalid) begin
                    byte_d  = inbyte;
                    state_d = ST_BSETUP;
                end else if (tmo_hit) begin
                    code_d  = {4'h0, state_q};
                    state_d = ST_ERR;
                end
            end
            ST_BSETUP: begin
                apb_start = 1'b1;
                state_d   = ST_BACCESS;
            end
            ST_BACCESS: begin
                if (apb_done) begin
                    if (apb_err) begin
                        code_d  = {4'h0, state_q};
                        state_d = ST_ERR;
                    end else if (cnt_q == LAST) begin
                        state_d = ST_CSETUP;
                    end else begin
                        cnt_d   = cnt_q + 10'd1;
                        state_d = ST_FILL;
                    end
                end else if (tmo_hit) begin
                    apb_abort = 1'b1;
                    code_d    = {4'h0, state_q};
                    state_d   = ST_ERR;
                end
            end
            ST_CSETUP: begin
                apb_start = 1'b1;
                state_d   = ST_CACCESS;
            end
            ST_CACCESS: begin
                if (apb_done) begin
                    if (apb_err) begin
                        code_d  = {4'h0, state_q};
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WBUSY;
                    end
                end else if (tmo_hit) begin
                    apb_abort = 1'b1;
                    code_d    = {4'h0, state_q};
                    state_d   = ST_ERR;
                end
            end
            ST_WBUSY: begin
                if (sdsbusy && (sdspi_status[7:0] != 8'h00)) begin
                    state_d = ST_WIDLE;
                end else if (tmo_hit) begin
                    code_d  = {4'h0, state_q};
                    state_d = ST_ERR;
                end
            end
            ST_WIDLE: begin
                if (sd_idle(sdsbusy, sdspi_status)) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    code_d  = {4'h0, state_q};
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                werr_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Wait budget restarts on every state change so each wait is bounded on its own.
        tmo_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : tmo_q + 24'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            sector_q <= '0;
            werr_q   <= 1'b0;
            code_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            sector_q <= sector_d;
            werr_q   <= werr_d;
            code_q   <= code_d;
            tmo_q    <= tmo_d;
        end
    end

    sdspi_apb_wr u_apb (
        .clk     (clk),
        .rstn    (rstn),
        .start   (apb_start),
        .abort   (apb_abort),
        .addr    (apb_addr),
        .data    (apb_data),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .pslverr (pslverr),
        .done    (apb_done),
        .err     (apb_err)
    );

    assign wbusy           = (state_q != ST_IDLE);
    assign wdone           = (state_q == ST_DONE);
    assign werr            = werr_q;
    assign inready         = (state_q == ST_FILL);
    assign inaddr          = cnt_q[8:0];
    assign w_writer_status = {16'h0000, code_q, 4'h0, state_q};

endmodule
